multicycle_ctrl: RTL

- Multi-cycle sequencer for the MIPS-lite datapath: addu, subu, slt, jr, ori, lw, sw, beq, lui, j, addi, addiu, jal.
- Replaces the single-cycle decode with an FSM that steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives IR/PC/register-file/data-memory enables and per-state datapath selects.
- Owns a req/ack handshake to data memory, with a bounded wait.

---
 rtl/multicycle_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS-lite datapath.
// Define ILLEGAL_TRAP_EN to halt on illegal instructions instead of retiring them as NOPs.
module multicycle_ctrl #(
  parameter int unsigned DM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  input  logic       dm_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemToReg,
  output logic [1:0] ExtOp,
  output logic [2:0] ALUctr,
  output logic       dm_req,
  output logic       dm_we,
  output logic       retire,
  output logic       bus_err,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_e;

  typedef enum logic [3:0] {
    CLS_ADDU, CLS_SUBU, CLS_SLT, CLS_JR, CLS_ORI, CLS_LW, CLS_SW,
    CLS_BEQ, CLS_LUI, CLS_J, CLS_ADDI, CLS_ADDIU, CLS_JAL, CLS_ILL
  } cls_e;

  localparam logic [7:0] WAIT_LAST = 8'(DM_WAIT_MAX - 1);

  state_e     state_q;
  cls_e       cls_q;
  cls_e       cls_d;
  cls_e       sel_cls;
  logic [7:0] wait_q;
  logic       ovf_q;
  logic       mem_timeout;

  always_comb begin
    cls_d = CLS_ILL;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b100001: cls_d = CLS_ADDU;
          6'b100011: cls_d = CLS_SUBU;
          6'b101010: cls_d = CLS_SLT;
          6'b001000: cls_d = CLS_JR;
          default:   cls_d = CLS_ILL;
        endcase
      end
      6'b001101: cls_d = CLS_ORI;
      6'b100011: cls_d = CLS_LW;
      6'b101011: cls_d = CLS_SW;
      6'b000100: cls_d = CLS_BEQ;
      6'b001111: cls_d = CLS_LUI;
      6'b000010: cls_d = CLS_J;
      6'b001000: cls_d = CLS_ADDI;
      6'b001001: cls_d = CLS_ADDIU;
      6'b000011: cls_d = CLS_JAL;
      default:   cls_d = CLS_ILL;
    endcase
  end

  // The class is only latched at the end of DECODE, so DECODE itself drives selects from the live decode.
  assign sel_cls     = (state_q == S_DECODE) ? cls_d : cls_q;
  assign mem_timeout = (state_q == S_MEM) && !dm_ack && (wait_q == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_ILL;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          cls_q   <= cls_d;
          // NOTE: non-blocking assignments; the last one scheduled in this block wins.
          state_q <= S_EXEC;
`ifdef ILLEGAL_TRAP_EN
          if (cls_d == CLS_ILL) state_q <= S_HALT;
`endif
        end
        S_EXEC: begin
          ovf_q <= overflow;
          case (cls_q)
            CLS_LW, CLS_SW: state_q <= S_MEM;
            CLS_ADDU, CLS_SUBU, CLS_SLT, CLS_ORI, CLS_LUI, CLS_ADDI, CLS_ADDIU:
              state_q <= S_WB;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dm_ack) begin
            wait_q  <= '0;
            state_q <= (cls_q == CLS_LW) ? S_WB : S_FETCH;
          end else if (mem_timeout) begin
            wait_q  <= '0;
            state_q <= S_FETCH;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
        end
        S_WB: state_q <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_HALT: state_q <= S_HALT;
`endif
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npc_sel  = 2'b00;
    reg_we   = 1'b0;
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    MemToReg = 2'b00;
    ExtOp    = 2'b00;
    ALUctr   = 3'b111;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    retire   = 1'b0;
    bus_err  = 1'b0;
    halted   = 1'b0;
    // Gating on rst_n keeps every output quiet while reset is held, even though FETCH is the reset state.
    if (rst_n) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        case (sel_cls)
          CLS_ADDU: ALUctr = 3'b010;
          CLS_SUBU: ALUctr = 3'b110;
          CLS_SLT:  ALUctr = 3'b000;
          CLS_BEQ: begin
            ALUctr = 3'b110;
            ExtOp  = 2'b01;
          end
          CLS_ORI: begin
            ALUctr = 3'b001;
            ALUSrc = 1'b1;
          end
          CLS_LUI: begin
            ALUctr = 3'b011;
            ALUSrc = 1'b1;
          end
          CLS_ADDI, CLS_ADDIU, CLS_LW, CLS_SW: begin
            ALUctr = 3'b010;
            ALUSrc = 1'b1;
            ExtOp  = 2'b01;
          end
          default: ALUctr = 3'b111;
        endcase
      end

      case (state_q)
        S_FETCH: ir_we = 1'b1;
        S_EXEC: begin
          case (cls_q)
            CLS_BEQ: begin
              pc_we   = 1'b1;
              npc_sel = zero ? 2'b01 : 2'b00;
              retire  = 1'b1;
            end
            CLS_J: begin
              pc_we   = 1'b1;
              npc_sel = 2'b10;
              retire  = 1'b1;
            end
            CLS_JAL: begin
              pc_we    = 1'b1;
              npc_sel  = 2'b10;
              retire   = 1'b1;
              reg_we   = 1'b1;
              RegDst   = 2'b10;
              MemToReg = 2'b10;
            end
            CLS_JR: begin
              pc_we   = 1'b1;
              npc_sel = 2'b11;
              retire  = 1'b1;
            end
            CLS_ILL: begin
              pc_we  = 1'b1;
              retire = 1'b1;
            end
            default: pc_we = 1'b0;
          endcase
        end
        S_MEM: begin
          dm_req = 1'b1;
          dm_we  = (cls_q == CLS_SW);
          if (dm_ack && cls_q == CLS_SW) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else if (mem_timeout) begin
            bus_err = 1'b1;
            pc_we   = 1'b1;
          end
        end
        S_WB: begin
          pc_we    = 1'b1;
          retire   = 1'b1;
          reg_we   = !(cls_q == CLS_ADDI && ovf_q);
          RegDst   = (cls_q inside {CLS_ADDU, CLS_SUBU, CLS_SLT}) ? 2'b01 : 2'b00;
          MemToReg = (cls_q == CLS_LW) ? 2'b01 : 2'b00;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: halted = 1'b1;
`endif
        default: ir_we = 1'b0;
      endcase
    end
  end

endmodule
